// File: rtl/unidade_controle_jogo_if.sv
// Control/status bundle between the game FSM and the game datapath.
// The FSM (master) drives every strobe and reads the datapath flags; the datapath (slave) does the reverse.
interface unidade_controle_jogo_if;
    // Level/pulse semantics, no valid/ready pairs: strobes are Moore outputs that hold for the whole
    // state cycle; tem_jogada is a single-cycle pulse; every other flag is a level sampled at each rising edge.
    logic       iniciar;
    logic       tem_jogada;
    logic       acertouJogada;
    logic       jogadaAtualEQUALSacertoAnterior;
    logic       acertoAnteriorEQUALSzero;
    logic       fimS;
    logic       fimLedsOn;
    logic       fimLedsOff;
    logic       fimPiscaLeds;
    logic       timeout;

    logic       zeraT, contaT, zeraS, contaS, zeraR, registraR;
    logic       zeraA, registraA, contaA, contaPiscadas, contaLedsOn, contaLedsOff;
    logic       zeraL, registraL, displayFromMem, apagarAcertos, contaM, zeraM;
    logic [1:0] displayAddr;
    logic       pronto, ganhou, perdeu;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, tem_jogada, acertouJogada, jogadaAtualEQUALSacertoAnterior,
               acertoAnteriorEQUALSzero, fimS, fimLedsOn, fimLedsOff, fimPiscaLeds, timeout,
        output zeraT, contaT, zeraS, contaS, zeraR, registraR, zeraA, registraA, contaA,
               contaPiscadas, contaLedsOn, contaLedsOff, zeraL, registraL, displayFromMem,
               apagarAcertos, contaM, zeraM, displayAddr, pronto, ganhou, perdeu, db_estado
    );

    modport slave (
        output iniciar, tem_jogada, acertouJogada, jogadaAtualEQUALSacertoAnterior,
               acertoAnteriorEQUALSzero, fimS, fimLedsOn, fimLedsOff, fimPiscaLeds, timeout,
        input  zeraT, contaT, zeraS, contaS, zeraR, registraR, zeraA, registraA, contaA,
               contaPiscadas, contaLedsOn, contaLedsOff, zeraL, registraL, displayFromMem,
               apagarAcertos, contaM, zeraM, displayAddr, pronto, ganhou, perdeu, db_estado
    );
endinterface

// File: rtl/unidade_controle_jogo.sv
// Moore control FSM for the memory game: mode select, rounds of distinct hits, blink celebration, win/loss.
// Every output is a pure decode of the current state; db_estado exposes the state code.
module unidade_controle_jogo #(
    parameter int HITS_PER_ROUND = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    unidade_controle_jogo_if.master bus
);
    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        ESCOLHE_MODO = 4'd1,
        PREPARA      = 4'd2,
        ESPERA       = 4'd3,
        REGISTRA     = 4'd4,
        COMPARA      = 4'd5,
        ACERTO       = 4'd6,
        PISCA_ON     = 4'd7,
        PISCA_OFF    = 4'd8,
        PROXIMA      = 4'd9,
        GANHOU       = 4'd10,
        PERDEU       = 4'd11
    } state_t;

    localparam logic [1:0] LAST_HIT = 2'(HITS_PER_ROUND - 1);

    state_t     state, next_state;
    logic [1:0] hit_count;
    logic       iniciar_prev;
    logic       iniciar_rise;
    logic       last_hit;
    logic       new_hit;

    assign iniciar_rise = bus.iniciar & ~iniciar_prev;
    assign last_hit     = (hit_count == LAST_HIT);
    // A repeat of the previous hit is not a new hit unless nothing has been hit yet.
    assign new_hit      = bus.acertouJogada &
                          (bus.acertoAnteriorEQUALSzero | ~bus.jogadaAtualEQUALSacertoAnterior);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= INICIAL;
            hit_count    <= 2'd0;
            iniciar_prev <= 1'b0;
        end else begin
            state        <= next_state;
            iniciar_prev <= bus.iniciar;
            if (state == INICIAL || state == PREPARA)
                hit_count <= 2'd0;
            else if (state == ACERTO)
                hit_count <= last_hit ? 2'd0 : hit_count + 2'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            INICIAL:      if (bus.iniciar) next_state = ESCOLHE_MODO;
            ESCOLHE_MODO: if (iniciar_rise) next_state = PREPARA;
            PREPARA:      next_state = ESPERA;
            ESPERA: begin
                if (bus.timeout)         next_state = PERDEU;
                else if (bus.tem_jogada) next_state = REGISTRA;
            end
            REGISTRA:     next_state = COMPARA;
            COMPARA: begin
                if (bus.timeout)  next_state = PERDEU;
                else if (new_hit) next_state = ACERTO;
                else              next_state = ESPERA;
            end
            ACERTO:       next_state = last_hit ? PISCA_ON : ESPERA;
            PISCA_ON:     if (bus.fimLedsOn) next_state = PISCA_OFF;
            PISCA_OFF: begin
                if (bus.fimLedsOff)
                    next_state = !bus.fimPiscaLeds ? PISCA_ON : (bus.fimS ? GANHOU : PROXIMA);
            end
            PROXIMA:      next_state = PREPARA;
            GANHOU:       if (bus.iniciar) next_state = INICIAL;
            PERDEU:       if (bus.iniciar) next_state = INICIAL;
            default:      next_state = INICIAL;
        endcase
    end

    always_comb begin
        bus.zeraT          = 1'b0;
        bus.contaT         = 1'b0;
        bus.zeraS          = 1'b0;
        bus.contaS         = 1'b0;
        bus.zeraR          = 1'b0;
        bus.registraR      = 1'b0;
        bus.zeraA          = 1'b0;
        bus.registraA      = 1'b0;
        bus.contaA         = 1'b0;
        bus.contaPiscadas  = 1'b0;
        bus.contaLedsOn    = 1'b0;
        bus.contaLedsOff   = 1'b0;
        bus.zeraL          = 1'b0;
        bus.registraL      = 1'b0;
        bus.displayFromMem = 1'b0;
        bus.apagarAcertos  = 1'b0;
        bus.contaM         = 1'b0;
        bus.zeraM          = 1'b0;
        bus.displayAddr    = 2'd0;
        bus.pronto         = 1'b0;
        bus.ganhou         = 1'b0;
        bus.perdeu         = 1'b0;
        bus.db_estado      = state;
        case (state)
            INICIAL: begin
                bus.zeraT = 1'b1; bus.zeraS = 1'b1; bus.zeraR = 1'b1; bus.zeraA = 1'b1;
                bus.zeraL = 1'b1; bus.zeraM = 1'b1;
                bus.displayFromMem = 1'b1; bus.apagarAcertos = 1'b1;
            end
            ESCOLHE_MODO: begin
                bus.contaM = 1'b1; bus.displayFromMem = 1'b1; bus.apagarAcertos = 1'b1;
                bus.displayAddr = 2'd1;
            end
            PREPARA: begin
                bus.zeraT = 1'b1; bus.zeraR = 1'b1; bus.zeraA = 1'b1; bus.registraL = 1'b1;
            end
            ESPERA:   bus.contaT = 1'b1;
            REGISTRA: begin bus.contaT = 1'b1; bus.registraR = 1'b1; end
            COMPARA:  bus.contaT = 1'b1;
            ACERTO:   begin bus.contaT = 1'b1; bus.contaA = 1'b1; bus.registraA = 1'b1; end
            PISCA_ON: bus.contaLedsOn = 1'b1;
            PISCA_OFF: begin
                bus.contaLedsOff = 1'b1; bus.contaPiscadas = 1'b1; bus.zeraL = 1'b1;
            end
            PROXIMA:  bus.contaS = 1'b1;
            GANHOU: begin
                bus.pronto = 1'b1; bus.ganhou = 1'b1; bus.displayFromMem = 1'b1;
                bus.displayAddr = 2'd2;
            end
            PERDEU: begin
                bus.pronto = 1'b1; bus.perdeu = 1'b1; bus.displayFromMem = 1'b1;
                bus.displayAddr = 2'd3;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench for the game control FSM: reset, mode select, hit counting, blink/win, timeout/loss.
module tb_unidade_controle_jogo;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    unidade_controle_jogo_if bus();

    unidade_controle_jogo #(.HITS_PER_ROUND(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        bus.iniciar = 1'b0; bus.tem_jogada = 1'b0; bus.acertouJogada = 1'b0;
        bus.jogadaAtualEQUALSacertoAnterior = 1'b0; bus.acertoAnteriorEQUALSzero = 1'b0;
        bus.fimS = 1'b0; bus.fimLedsOn = 1'b0; bus.fimLedsOff = 1'b0;
        bus.fimPiscaLeds = 1'b0; bus.timeout = 1'b0;
    endtask

    // Drive one press through ESPERA -> REGISTRA -> COMPARA -> (ACERTO|ESPERA).
    task automatic press(input logic acertou, input logic eq_prev, input logic prev_zero);
        bus.tem_jogada = 1'b1;
        bus.acertouJogada = acertou;
        bus.jogadaAtualEQUALSacertoAnterior = eq_prev;
        bus.acertoAnteriorEQUALSzero = prev_zero;
        tick;
        bus.tem_jogada = 1'b0;
        tick;
        tick;
    endtask

    task automatic go_to_espera;
        bus.iniciar = 1'b1; tick;
        bus.iniciar = 1'b0; tick;
        bus.iniciar = 1'b1; tick;
        bus.iniciar = 1'b0; tick;
    endtask

    task automatic test_reset;
        clear_inputs();
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.db_estado !== 4'd0) begin errors++; $display("FAIL reset_state: db_estado=%0d expected 0", bus.db_estado); end
        checks++; if ({bus.zeraT, bus.zeraS, bus.zeraM, bus.displayFromMem, bus.apagarAcertos} !== 5'b11111) begin errors++; $display("FAIL reset_outputs: got %b expected 11111", {bus.zeraT, bus.zeraS, bus.zeraM, bus.displayFromMem, bus.apagarAcertos}); end
        checks++; if (bus.displayAddr !== 2'd0) begin errors++; $display("FAIL reset_display: displayAddr=%0d expected 0", bus.displayAddr); end
        tick; tick;
        reset = 1'b1;
        tick;
        checks++; if (bus.db_estado !== 4'd0) begin errors++; $display("FAIL reset_idle: db_estado=%0d expected 0", bus.db_estado); end
    endtask

    task automatic test_start;
        bus.iniciar = 1'b1; tick;
        checks++; if (bus.db_estado !== 4'd1) begin errors++; $display("FAIL start_mode: db_estado=%0d expected 1", bus.db_estado); end
        checks++; if (bus.contaM !== 1'b1 || bus.displayAddr !== 2'd1) begin errors++; $display("FAIL start_mode_out: contaM=%b displayAddr=%0d expected 1/1", bus.contaM, bus.displayAddr); end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (bus.db_estado !== 4'd1) begin errors++; $display("FAIL start_held: db_estado=%0d expected 1", bus.db_estado); end
        end
        bus.iniciar = 1'b0; tick;
        checks++; if (bus.db_estado !== 4'd1) begin errors++; $display("FAIL start_low: db_estado=%0d expected 1", bus.db_estado); end
        bus.iniciar = 1'b1; tick;
        bus.iniciar = 1'b0;
        checks++; if (bus.db_estado !== 4'd2 || bus.registraL !== 1'b1 || bus.zeraT !== 1'b1) begin errors++; $display("FAIL start_prepara: db_estado=%0d registraL=%b zeraT=%b expected 2/1/1", bus.db_estado, bus.registraL, bus.zeraT); end
        tick;
        checks++; if (bus.db_estado !== 4'd3 || bus.contaT !== 1'b1) begin errors++; $display("FAIL start_espera: db_estado=%0d contaT=%b expected 3/1", bus.db_estado, bus.contaT); end
        tick;
        checks++; if (bus.db_estado !== 4'd3) begin errors++; $display("FAIL espera_idle: db_estado=%0d expected 3", bus.db_estado); end
    endtask

    task automatic test_hits;
        int pulses = 0;
        for (int i = 0; i < 3; i++) begin
            bus.tem_jogada = 1'b1; bus.acertouJogada = 1'b1;
            bus.jogadaAtualEQUALSacertoAnterior = 1'b0; bus.acertoAnteriorEQUALSzero = (i == 0);
            tick;
            bus.tem_jogada = 1'b0;
            checks++; if (bus.db_estado !== 4'd4 || bus.registraR !== 1'b1) begin errors++; $display("FAIL hit%0d_registra: db_estado=%0d registraR=%b expected 4/1", i, bus.db_estado, bus.registraR); end
            tick;
            checks++; if (bus.db_estado !== 4'd5) begin errors++; $display("FAIL hit%0d_compara: db_estado=%0d expected 5", i, bus.db_estado); end
            tick;
            if (bus.contaA === 1'b1) pulses++;
            checks++; if (bus.db_estado !== 4'd6 || bus.registraA !== 1'b1) begin errors++; $display("FAIL hit%0d_acerto: db_estado=%0d registraA=%b expected 6/1", i, bus.db_estado, bus.registraA); end
            tick;
            checks++; if (bus.db_estado !== ((i == 2) ? 4'd7 : 4'd3)) begin errors++; $display("FAIL hit%0d_after: db_estado=%0d expected %0d", i, bus.db_estado, (i == 2) ? 7 : 3); end
        end
        checks++; if (pulses !== 3) begin errors++; $display("FAIL hits_contaA: pulses=%0d expected 3", pulses); end
        checks++; if (bus.contaLedsOn !== 1'b1) begin errors++; $display("FAIL hits_pisca_on: contaLedsOn=%b expected 1", bus.contaLedsOn); end
        clear_inputs();
    endtask

    task automatic test_next_round;
        bus.timeout = 1'b1;
        bus.fimLedsOn = 1'b1; tick;
        bus.fimLedsOn = 1'b0;
        checks++; if (bus.db_estado !== 4'd8 || bus.contaPiscadas !== 1'b1 || bus.zeraL !== 1'b1) begin errors++; $display("FAIL next_pisca_off: db_estado=%0d contaPiscadas=%b zeraL=%b expected 8/1/1", bus.db_estado, bus.contaPiscadas, bus.zeraL); end
        bus.fimLedsOff = 1'b1; bus.fimPiscaLeds = 1'b1; bus.fimS = 1'b0; tick;
        bus.fimLedsOff = 1'b0; bus.fimPiscaLeds = 1'b0;
        checks++; if (bus.db_estado !== 4'd9 || bus.contaS !== 1'b1) begin errors++; $display("FAIL next_proxima: db_estado=%0d contaS=%b expected 9/1", bus.db_estado, bus.contaS); end
        tick;
        checks++; if (bus.db_estado !== 4'd2) begin errors++; $display("FAIL next_prepara: db_estado=%0d expected 2", bus.db_estado); end
        bus.timeout = 1'b0; tick;
        checks++; if (bus.db_estado !== 4'd3) begin errors++; $display("FAIL next_espera: db_estado=%0d expected 3", bus.db_estado); end
    endtask

    task automatic test_repeat;
        press(1'b1, 1'b0, 1'b1);
        checks++; if (bus.db_estado !== 4'd6) begin errors++; $display("FAIL repeat_first: db_estado=%0d expected 6", bus.db_estado); end
        tick;
        press(1'b1, 1'b1, 1'b0);
        checks++; if (bus.db_estado !== 4'd3 || bus.contaA !== 1'b0) begin errors++; $display("FAIL repeat_second: db_estado=%0d contaA=%b expected 3/0", bus.db_estado, bus.contaA); end
        press(1'b0, 1'b0, 1'b0);
        checks++; if (bus.db_estado !== 4'd3) begin errors++; $display("FAIL repeat_wrong: db_estado=%0d expected 3", bus.db_estado); end
        press(1'b1, 1'b0, 1'b0);
        tick;
        checks++; if (bus.db_estado !== 4'd3) begin errors++; $display("FAIL repeat_hit2: db_estado=%0d expected 3", bus.db_estado); end
        press(1'b1, 1'b0, 1'b0);
        tick;
        checks++; if (bus.db_estado !== 4'd7) begin errors++; $display("FAIL repeat_hit3: db_estado=%0d expected 7", bus.db_estado); end
        clear_inputs();
    endtask

    task automatic test_win;
        bus.fimS = 1'b1; bus.timeout = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if (bus.db_estado !== 4'd7) begin errors++; $display("FAIL win_hold_on%0d: db_estado=%0d expected 7", k, bus.db_estado); end
            bus.fimLedsOn = 1'b1; tick;
            bus.fimLedsOn = 1'b0;
            checks++; if (bus.db_estado !== 4'd8) begin errors++; $display("FAIL win_off%0d: db_estado=%0d expected 8", k, bus.db_estado); end
            bus.fimLedsOff = 1'b1; bus.fimPiscaLeds = (k == 2); tick;
            bus.fimLedsOff = 1'b0; bus.fimPiscaLeds = 1'b0;
            checks++; if (bus.db_estado !== ((k == 2) ? 4'd10 : 4'd7)) begin errors++; $display("FAIL win_blink%0d: db_estado=%0d expected %0d", k, bus.db_estado, (k == 2) ? 10 : 7); end
        end
        checks++; if ({bus.pronto, bus.ganhou, bus.perdeu} !== 3'b110 || bus.displayAddr !== 2'd2) begin errors++; $display("FAIL win_outputs: pronto/ganhou/perdeu=%b displayAddr=%0d expected 110/2", {bus.pronto, bus.ganhou, bus.perdeu}, bus.displayAddr); end
        clear_inputs();
        tick;
        checks++; if (bus.db_estado !== 4'd10) begin errors++; $display("FAIL win_hold: db_estado=%0d expected 10", bus.db_estado); end
        bus.iniciar = 1'b1; tick;
        bus.iniciar = 1'b0;
        checks++; if (bus.db_estado !== 4'd0) begin errors++; $display("FAIL win_restart: db_estado=%0d expected 0", bus.db_estado); end
        tick;
    endtask

    task automatic test_timeout;
        go_to_espera();
        checks++; if (bus.db_estado !== 4'd3) begin errors++; $display("FAIL timeout_setup: db_estado=%0d expected 3", bus.db_estado); end
        bus.timeout = 1'b1; bus.tem_jogada = 1'b1; tick;
        clear_inputs();
        checks++; if (bus.db_estado !== 4'd11) begin errors++; $display("FAIL timeout_perdeu: db_estado=%0d expected 11", bus.db_estado); end
        checks++; if ({bus.pronto, bus.ganhou, bus.perdeu} !== 3'b101 || bus.displayAddr !== 2'd3) begin errors++; $display("FAIL timeout_outputs: pronto/ganhou/perdeu=%b displayAddr=%0d expected 101/3", {bus.pronto, bus.ganhou, bus.perdeu}, bus.displayAddr); end
        bus.iniciar = 1'b1; tick;
        bus.iniciar = 1'b0;
        checks++; if (bus.db_estado !== 4'd0) begin errors++; $display("FAIL timeout_restart: db_estado=%0d expected 0", bus.db_estado); end
        tick;
    endtask

    task automatic test_reset_mid;
        go_to_espera();
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.db_estado !== 4'd0) begin errors++; $display("FAIL reset_mid_state: db_estado=%0d expected 0", bus.db_estado); end
        checks++; if (bus.zeraT !== 1'b1 || bus.zeraS !== 1'b1 || bus.contaT !== 1'b0) begin errors++; $display("FAIL reset_mid_out: zeraT=%b zeraS=%b contaT=%b expected 1/1/0", bus.zeraT, bus.zeraS, bus.contaT); end
        tick;
        reset = 1'b1;
        tick;
    endtask

    initial begin
        test_reset();
        test_start();
        test_hits();
        test_next_round();
        test_repeat();
        test_win();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/unidade_controle_jogo.md
Name: unidade_controle_jogo

Overview:
- Moore-style control FSM that sits directly upstream of the game datapath.
- Drives every datapath control strobe: timers, sequence/hit/mode counters, jogada/acerto/LED registers, display muxing and blink counters.
- Consumes the datapath status flags.
- Sequences the flow: mode select → per-round LED pattern → collect HITS_PER_ROUND distinct correct presses before timeout → blink celebration → next round, until the sequence ends (win) or the timer expires (loss).

Parameters:
- HITS_PER_ROUND, 3, distinct correct presses required to clear one round (1..3).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset); forces INICIAL immediately.
- iniciar  in  1  level start button; sampled in INICIAL and ESCOLHE_MODO.
- tem_jogada  in  1  one-cycle pulse on a new button press.
- acertouJogada  in  1  registered jogada overlaps the expected pattern.
- jogadaAtualEQUALSacertoAnterior  in  1  registered jogada equals previous hit.
- acertoAnteriorEQUALSzero  in  1  no previous hit stored.
- fimS  in  1  last sequence position reached.
- fimLedsOn, fimLedsOff, fimPiscaLeds  in  1 each  blink timer/counter terminal flags.
- timeout  in  1  registered round timer expiry.
- zeraT, contaT, zeraS, contaS, zeraR, registraR, zeraA, registraA, contaA, contaPiscadas, contaLedsOn, contaLedsOff, zeraL, registraL, displayFromMem, apagarAcertos, contaM, zeraM  out  1 each  datapath strobes.
- displayAddr  out  2  message select: 0 idle, 1 mode, 2 win, 3 loss.
- pronto  out  1  game finished (win or loss).
- ganhou  out  1  win indicator.
- perdeu  out  1  loss indicator.
- db_estado  out  4  current state code.

Behaviour:
- All outputs decode from state only. No output depends combinationally on an input.
- Reset: state INICIAL (code 0); internal hit count 0.
- Default output value is 0 unless listed for a state.

States and outputs (code, name: asserted outputs):
- 0 INICIAL: zeraT, zeraS, zeraR, zeraA, zeraL, zeraM, displayFromMem, apagarAcertos; displayAddr=0.
- 1 ESCOLHE_MODO: contaM, displayFromMem, apagarAcertos; displayAddr=1.
- 2 PREPARA: zeraT, zeraR, zeraA, registraL.
- 3 ESPERA: contaT.
- 4 REGISTRA: contaT, registraR.
- 5 COMPARA: contaT.
- 6 ACERTO: contaT, contaA, registraA.
- 7 PISCA_ON: contaLedsOn.
- 8 PISCA_OFF: contaLedsOff, contaPiscadas, zeraL.
- 9 PROXIMA: contaS.
- 10 GANHOU: pronto, ganhou, displayFromMem; displayAddr=2.
- 11 PERDEU: pronto, perdeu, displayFromMem; displayAddr=3.

Transitions:
- INICIAL → ESCOLHE_MODO when iniciar=1.
- ESCOLHE_MODO → PREPARA on a rising edge of iniciar. Requires iniciar to be seen 0 then 1; an internal edge register is cleared by reset.
- PREPARA → ESPERA.
- ESPERA:
  - timeout=1 → PERDEU.
  - else tem_jogada=1 → REGISTRA.
  - else stay.
  - timeout has priority when both are high in the same cycle.
- REGISTRA → COMPARA. This gives one cycle of register latency.
- COMPARA:
  - timeout → PERDEU.
  - acertouJogada=1 and (acertoAnteriorEQUALSzero=1 or jogadaAtualEQUALSacertoAnterior=0) → ACERTO.
  - otherwise → ESPERA. A wrong or repeated press is ignored with no penalty.
- ACERTO:
  - Increment internal hit count.
  - If the count before increment = HITS_PER_ROUND−1 → PISCA_ON and clear the count.
  - Else → ESPERA.
- PISCA_ON → PISCA_OFF when fimLedsOn.
- PISCA_OFF:
  - fimLedsOff and fimPiscaLeds → PROXIMA if fimS=0, else GANHOU.
  - fimLedsOff only → PISCA_ON.
- PROXIMA → PREPARA.
- GANHOU, PERDEU → INICIAL when iniciar=1.
- Unused codes 12–15 → INICIAL.

Boundary conditions:
- reset low mid-round: immediate return to INICIAL.
- timeout is ignored in the PISCA states and PROXIMA, because the timer is not counting there.
- Hit count is 2 bits, saturating-free, and is cleared in PREPARA and INICIAL.

Test Plan:
- Reset low mid-ESPERA → db_estado=0 asynchronously; zeraT=zeraS=1, contaT=0.
- iniciar held 1 through INICIAL → stays in ESCOLHE_MODO until iniciar drops and rises again; then PREPARA for exactly 1 cycle, registraL=1, then ESPERA with contaT=1.
- Three tem_jogada pulses, each followed by acertouJogada=1 with jogadaAtualEQUALSacertoAnterior=0 → contaA pulses 3 times; state goes to PISCA_ON after the third.
- Same correct press twice (second with jogadaAtualEQUALSacertoAnterior=1, acertoAnteriorEQUALSzero=0) → no contaA on the second press; returns to ESPERA.
- Blink with fimPiscaLeds on the 3rd PISCA_OFF and fimS=1 → GANHOU; pronto=ganhou=1, displayAddr=2.
- timeout=1 and tem_jogada=1 in the same ESPERA cycle → PERDEU; perdeu=1, displayAddr=3; iniciar → INICIAL.
